// File: rtl/fb_rect_fill.sv
// Rectangle fill engine: writes a solid 12-bit colour into a clipped
// rectangle of a 640x480x16bpp framebuffer using Avalon-MM write bursts.
module fb_rect_fill #(
  parameter int unsigned MAX_BURST  = 8,
  parameter logic [31:0] FRAME_SIZE = 32'h00096000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  avalon_slave_address,
  input  logic        avalon_slave_read,
  output logic [31:0] avalon_slave_readdata,
  input  logic        avalon_slave_write,
  input  logic [31:0] avalon_slave_writedata,
  output logic [31:0] avalon_master_address,
  output logic [4:0]  avalon_master_burstcount,
  output logic        avalon_master_write,
  output logic [31:0] avalon_master_writedata,
  output logic [3:0]  avalon_master_byteenable,
  input  logic        avalon_master_waitrequest,
  output logic        irq
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_BURST,
    S_NEXT_ROW,
    S_DONE
  } state_t;

  localparam logic [4:0] MAXB5  = 5'(MAX_BURST);
  localparam logic [9:0] MAXB10 = 10'(MAX_BURST);

  state_t      state_q, state_d;

  // Software-visible registers
  logic [31:0] base_q, base_d;
  logic        frame_q, frame_d;
  logic [9:0]  x0_q, x0_d;
  logic [9:0]  y0_q, y0_d;
  logic [10:0] w_q, w_d;
  logic [9:0]  h_q, h_d;
  logic [11:0] color_q, color_d;
  logic        irq_q, irq_d;
  logic [31:0] rdata_q, rdata_d;

  // Working copies latched at start
  logic [31:0] wbase_q, wbase_d;
  logic        wframe_q, wframe_d;
  logic [9:0]  wx0_q, wx0_d;
  logic [9:0]  wy0_q, wy0_d;
  logic [10:0] ww_q, ww_d;
  logic [9:0]  wh_q, wh_d;
  logic [11:0] wcolor_q, wcolor_d;

  // Fill progress
  logic [9:0]  y_q, y_d;
  logic [9:0]  wx_q, wx_d;
  logic [9:0]  rem_q, rem_d;
  logic [4:0]  beats_q, beats_d;

  // Registered master outputs
  logic [31:0] maddr_q, maddr_d;
  logic [4:0]  mbc_q, mbc_d;
  logic        mwrite_q, mwrite_d;
  logic [3:0]  mbe_q, mbe_d;

  // Clipping and span signals
  logic [11:0] x_end;
  logic [10:0] x1;
  logic [10:0] y_end;
  logic [9:0]  y1;
  logic        empty;
  logic [9:0]  word_lo;
  logic [9:0]  word_hi;
  logic [9:0]  span;
  logic [9:0]  src_wx;
  logic [9:0]  src_rem;
  logic [4:0]  src_len;
  logic [31:0] src_addr;
  logic        wr_en;
  logic        start;
  logic        irq_clr;

  function automatic logic [3:0] be_for(input logic [9:0] w, input logic [9:0] lo,
                                        input logic [9:0] hi, input logic lo_odd,
                                        input logic hi_odd);
    logic [3:0] b;
    b = 4'hF;
    if (w == lo && lo_odd) b = b & 4'b1100;
    if (w == hi && hi_odd) b = b & 4'b0011;
    return b;
  endfunction

  assign avalon_slave_readdata    = rdata_q;
  assign avalon_master_address    = maddr_q;
  assign avalon_master_burstcount = mbc_q;
  assign avalon_master_write      = mwrite_q;
  assign avalon_master_byteenable = mbe_q;
  assign avalon_master_writedata  = {4'h0, wcolor_q, 4'h0, wcolor_q};
  assign irq                      = irq_q;

  // Clip window, word span and next-burst parameters from the working copies
  always_comb begin
    x_end   = {2'b00, wx0_q} + {1'b0, ww_q};
    x1      = (x_end > 12'd640) ? 11'd640 : x_end[10:0];
    y_end   = {1'b0, wy0_q} + {1'b0, wh_q};
    y1      = (y_end > 11'd480) ? 10'd480 : y_end[9:0];
    empty   = (x1 <= {1'b0, wx0_q}) || (y1 <= wy0_q);
    word_lo = {1'b0, wx0_q[9:1]};
    word_hi = 10'((x1 - 11'd1) >> 1);
    span    = word_hi - word_lo + 10'd1;
    src_wx  = (state_q == S_SETUP) ? word_lo : wx_q;
    src_rem = (state_q == S_SETUP) ? span : rem_q;
    src_len = (src_rem > MAXB10) ? MAXB5 : src_rem[4:0];
    src_addr = wbase_q + (wframe_q ? FRAME_SIZE : '0) + ({22'd0, y_q} * 32'd1280)
             + {20'd0, src_wx, 2'b00};
  end

  // Register file, read mux, interrupt and fill sequencing
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    frame_d  = frame_q;
    x0_d     = x0_q;
    y0_d     = y0_q;
    w_d      = w_q;
    h_d      = h_q;
    color_d  = color_q;
    irq_d    = irq_q;
    rdata_d  = rdata_q;
    wbase_d  = wbase_q;
    wframe_d = wframe_q;
    wx0_d    = wx0_q;
    wy0_d    = wy0_q;
    ww_d     = ww_q;
    wh_d     = wh_q;
    wcolor_d = wcolor_q;
    y_d      = y_q;
    wx_d     = wx_q;
    rem_d    = rem_q;
    beats_d  = beats_q;
    maddr_d  = maddr_q;
    mbc_d    = mbc_q;
    mwrite_d = mwrite_q;
    mbe_d    = mbe_q;

    wr_en   = avalon_slave_write && !avalon_slave_read;
    start   = wr_en && (avalon_slave_address == 3'd1) && avalon_slave_writedata[0];
    irq_clr = wr_en && (avalon_slave_address == 3'd1) && avalon_slave_writedata[2];

    if (wr_en) begin
      case (avalon_slave_address)
        3'd0: base_d  = avalon_slave_writedata;
        3'd1: frame_d = avalon_slave_writedata[1];
        3'd2: x0_d    = avalon_slave_writedata[9:0];
        3'd3: y0_d    = avalon_slave_writedata[9:0];
        3'd4: w_d     = avalon_slave_writedata[10:0];
        3'd5: h_d     = avalon_slave_writedata[9:0];
        3'd6: color_d = avalon_slave_writedata[11:0];
        default: ;
      endcase
    end

    if (avalon_slave_read) begin
      case (avalon_slave_address)
        3'd0: rdata_d = base_q;
        3'd1: rdata_d = {29'd0, wframe_q, irq_q, state_q != S_IDLE};
        3'd2: rdata_d = {22'd0, x0_q};
        3'd3: rdata_d = {22'd0, y0_q};
        3'd4: rdata_d = {21'd0, w_q};
        3'd5: rdata_d = {22'd0, h_q};
        3'd6: rdata_d = {20'd0, color_q};
        default: rdata_d = '0;
      endcase
    end

    // Clear first so a completion in the same cycle leaves irq set
    if (irq_clr) irq_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          wbase_d  = base_q;
          wframe_d = avalon_slave_writedata[1];
          wx0_d    = x0_q;
          wy0_d    = y0_q;
          ww_d     = w_q;
          wh_d     = h_q;
          wcolor_d = color_q;
          y_d      = y0_q;
          state_d  = S_SETUP;
        end
      end
      S_SETUP: begin
        if (empty) begin
          irq_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          wx_d     = word_lo;
          rem_d    = span;
          maddr_d  = src_addr;
          mbc_d    = src_len;
          beats_d  = src_len;
          mbe_d    = be_for(word_lo, word_lo, word_hi, wx0_q[0], x1[0]);
          mwrite_d = 1'b1;
          state_d  = S_BURST;
        end
      end
      S_BURST: begin
        // write low here is the mandatory gap cycle: load the next burst
        if (!mwrite_q) begin
          maddr_d  = src_addr;
          mbc_d    = src_len;
          beats_d  = src_len;
          mbe_d    = be_for(wx_q, word_lo, word_hi, wx0_q[0], x1[0]);
          mwrite_d = 1'b1;
        end else if (!avalon_master_waitrequest) begin
          wx_d    = wx_q + 10'd1;
          rem_d   = rem_q - 10'd1;
          beats_d = beats_q - 5'd1;
          mbe_d   = be_for(wx_q + 10'd1, word_lo, word_hi, wx0_q[0], x1[0]);
          if (beats_q == 5'd1) begin
            mwrite_d = 1'b0;
            if (rem_q == 10'd1) state_d = S_NEXT_ROW;
          end
        end
      end
      S_NEXT_ROW: begin
        y_d = y_q + 10'd1;
        if (y_q + 10'd1 == y1) begin
          irq_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_SETUP;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      frame_q  <= 1'b0;
      x0_q     <= '0;
      y0_q     <= '0;
      w_q      <= '0;
      h_q      <= '0;
      color_q  <= '0;
      irq_q    <= 1'b0;
      rdata_q  <= '0;
      wbase_q  <= '0;
      wframe_q <= 1'b0;
      wx0_q    <= '0;
      wy0_q    <= '0;
      ww_q     <= '0;
      wh_q     <= '0;
      wcolor_q <= '0;
      y_q      <= '0;
      wx_q     <= '0;
      rem_q    <= '0;
      beats_q  <= '0;
      maddr_q  <= '0;
      mbc_q    <= '0;
      mwrite_q <= 1'b0;
      mbe_q    <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      frame_q  <= frame_d;
      x0_q     <= x0_d;
      y0_q     <= y0_d;
      w_q      <= w_d;
      h_q      <= h_d;
      color_q  <= color_d;
      irq_q    <= irq_d;
      rdata_q  <= rdata_d;
      wbase_q  <= wbase_d;
      wframe_q <= wframe_d;
      wx0_q    <= wx0_d;
      wy0_q    <= wy0_d;
      ww_q     <= ww_d;
      wh_q     <= wh_d;
      wcolor_q <= wcolor_d;
      y_q      <= y_d;
      wx_q     <= wx_d;
      rem_q    <= rem_d;
      beats_q  <= beats_d;
      maddr_q  <= maddr_d;
      mbc_q    <= mbc_d;
      mwrite_q <= mwrite_d;
      mbe_q    <= mbe_d;
    end
  end

endmodule

// File: tb/tb_fb_rect_fill.sv
// Directed bench for fb_rect_fill: table of rectangles with hand-computed
// burst summaries plus a pixel-level memory image model.
module tb_fb_rect_fill;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  s_addr = '0;
  logic        s_read = 1'b0;
  logic [31:0] s_rdata;
  logic        s_write = 1'b0;
  logic [31:0] s_wdata = '0;
  logic [31:0] m_addr;
  logic [4:0]  m_bc;
  logic        m_write;
  logic [31:0] m_data;
  logic [3:0]  m_be;
  logic        m_wait = 1'b0;
  logic        irq;

  fb_rect_fill #(.MAX_BURST(8), .FRAME_SIZE(32'h00096000)) dut (
    .clk                       (clk),
    .reset_n                   (reset_n),
    .avalon_slave_address      (s_addr),
    .avalon_slave_read         (s_read),
    .avalon_slave_readdata     (s_rdata),
    .avalon_slave_write        (s_write),
    .avalon_slave_writedata    (s_wdata),
    .avalon_master_address     (m_addr),
    .avalon_master_burstcount  (m_bc),
    .avalon_master_write       (m_write),
    .avalon_master_writedata   (m_data),
    .avalon_master_byteenable  (m_be),
    .avalon_master_waitrequest (m_wait),
    .irq                       (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned x0, y0, w, h;
    logic        frame;
    logic [31:0] base;
    logic [11:0] color;
    logic        stall;
    int          n_beats, n_bursts;
    logic [31:0] f_addr;
    logic [4:0]  f_bc;
    logic [3:0]  f_be;
    logic [31:0] l_addr;
    logic [4:0]  l_bc;
    logic [3:0]  l_be;
  } vec_t;

  vec_t vecs[10];

  int total = 0;
  int bad = 0;

  // Monitor state (written only by the monitor)
  int          beats, bursts, prot_err, img_err;
  logic [31:0] first_addr, last_addr;
  logic [4:0]  first_bc, last_bc;
  logic [3:0]  first_be, last_be;
  logic        in_burst, expect_gap;
  int          bidx;
  logic [31:0] cap_addr;
  logic [4:0]  cap_bc;
  logic [3:0]  got_img[int unsigned];

  logic        mon_clr = 1'b0;
  logic        stall_en = 1'b0;
  logic [31:0] exp_data = '0;
  logic [3:0]  exp_img[int unsigned];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Bus monitor: burst framing, held address/burstcount, gap, beat capture
  always @(negedge clk) begin
    if (mon_clr || !reset_n) begin
      in_burst = 1'b0;
      expect_gap = 1'b0;
      if (mon_clr) begin
        beats = 0; bursts = 0; prot_err = 0; img_err = 0;
        first_addr = '0; last_addr = '0; first_bc = '0; last_bc = '0;
        first_be = '0; last_be = '0;
        got_img.delete();
      end
    end else if (expect_gap) begin
      if (m_write) prot_err++;
      expect_gap = 1'b0;
    end else if (m_write) begin
      if (!in_burst) begin
        in_burst = 1'b1;
        bidx = 0;
        cap_addr = m_addr;
        cap_bc = m_bc;
        bursts++;
        last_addr = m_addr;
        last_bc = m_bc;
        if (bursts == 1) begin
          first_addr = m_addr;
          first_bc = m_bc;
        end
      end else if (m_addr !== cap_addr || m_bc !== cap_bc) begin
        prot_err++;
      end
      if (!m_wait) begin
        int unsigned a;
        a = cap_addr + 32'(bidx * 4);
        if (got_img.exists(a)) img_err++;
        got_img[a] = m_be;
        if (m_data !== exp_data) img_err++;
        if (beats == 0) first_be = m_be;
        last_be = m_be;
        beats++;
        bidx++;
        if (bidx == int'(cap_bc)) begin
          in_burst = 1'b0;
          expect_gap = 1'b1;
        end
      end
    end
  end

  // Waitrequest generator
  initial begin
    forever begin
      @(posedge clk);
      #1 m_wait = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  task automatic clr_mon();
    mon_clr = 1'b1;
    @(negedge clk);
    #1 mon_clr = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(posedge clk);
    #1 s_addr = a; s_wdata = d; s_write = 1'b1;
    @(posedge clk);
    #1 s_write = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    @(posedge clk);
    #1 s_addr = a; s_read = 1'b1;
    @(posedge clk);
    #1 s_read = 1'b0;
    d = s_rdata;
  endtask

  // Pixel-level expected image: each covered pixel enables its halfword
  task automatic build_exp(input vec_t v);
    int unsigned x1, y1, a;
    exp_img.delete();
    x1 = (v.x0 + v.w > 640) ? 640 : v.x0 + v.w;
    y1 = (v.y0 + v.h > 480) ? 480 : v.y0 + v.h;
    for (int unsigned y = v.y0; y < y1; y++) begin
      for (int unsigned x = v.x0; x < x1; x++) begin
        a = v.base + (v.frame ? 32'h96000 : 32'h0) + y * 1280 + (x / 2) * 4;
        if (exp_img.exists(a)) exp_img[a] = exp_img[a] | ((x % 2) ? 4'b1100 : 4'b0011);
        else exp_img[a] = (x % 2) ? 4'b1100 : 4'b0011;
      end
    end
  endtask

  task automatic start_vec(input vec_t v);
    build_exp(v);
    clr_mon();
    stall_en = v.stall;
    exp_data = {4'h0, v.color, 4'h0, v.color};
    wr(3'd0, v.base);
    wr(3'd2, v.x0);
    wr(3'd3, v.y0);
    wr(3'd4, v.w);
    wr(3'd5, v.h);
    wr(3'd6, {20'd0, v.color});
    wr(3'd1, {30'd0, v.frame, 1'b1});
  endtask

  task automatic wait_irq(input string nm);
    for (int i = 0; i < 20000 && !irq; i++) @(negedge clk);
    chk({nm, "_irq"}, {31'd0, irq}, 32'd1);
  endtask

  task automatic finish_vec(input string nm, input vec_t v);
    logic [31:0] d;
    int e;
    wait_irq(nm);
    repeat (20) @(negedge clk);
    stall_en = 1'b0;
    chk({nm, "_beats"}, beats, v.n_beats);
    chk({nm, "_bursts"}, bursts, v.n_bursts);
    if (v.n_beats > 0) begin
      chk({nm, "_first_addr"}, first_addr, v.f_addr);
      chk({nm, "_first_bc"}, {27'd0, first_bc}, {27'd0, v.f_bc});
      chk({nm, "_first_be"}, {28'd0, first_be}, {28'd0, v.f_be});
      chk({nm, "_last_addr"}, last_addr, v.l_addr);
      chk({nm, "_last_bc"}, {27'd0, last_bc}, {27'd0, v.l_bc});
      chk({nm, "_last_be"}, {28'd0, last_be}, {28'd0, v.l_be});
    end
    e = (got_img.size() != exp_img.size()) ? 1 : 0;
    foreach (exp_img[k]) if (!got_img.exists(k) || got_img[k] !== exp_img[k]) e++;
    chk({nm, "_image"}, e, 0);
    chk({nm, "_beat_data"}, img_err, 0);
    chk({nm, "_protocol"}, prot_err, 0);
    rd(3'd1, d);
    chk({nm, "_ctrl_done"}, d, {29'd0, v.frame, 2'b10});
    wr(3'd1, 32'h4);
    @(negedge clk);
    chk({nm, "_irq_clear"}, {31'd0, irq}, 32'd0);
  endtask

  initial begin
    logic [31:0] d;
    int n;
    string nm;

    vecs[0] = '{3, 2, 1, 1, 1'b1, 32'h1000, 12'h123, 1'b0, 1, 1,
                32'h97A04, 5'd1, 4'hC, 32'h97A04, 5'd1, 4'hC};
    vecs[1] = '{1, 0, 40, 2, 1'b0, 32'h0, 12'h5A5, 1'b0, 42, 6,
                32'h0, 5'd8, 4'hC, 32'h540, 5'd5, 4'h3};
    vecs[2] = '{630, 479, 100, 5, 1'b0, 32'h0, 12'h0F0, 1'b0, 5, 1,
                32'h95FEC, 5'd5, 4'hF, 32'h95FEC, 5'd5, 4'hF};
    vecs[3] = '{10, 10, 0, 4, 1'b0, 32'h0, 12'h111, 1'b0, 0, 0,
                32'h0, 5'd0, 4'h0, 32'h0, 5'd0, 4'h0};
    vecs[4] = '{700, 0, 20, 1, 1'b0, 32'h0, 12'h222, 1'b0, 0, 0,
                32'h0, 5'd0, 4'h0, 32'h0, 5'd0, 4'h0};
    vecs[5] = '{0, 478, 640, 10, 1'b0, 32'h0, 12'hF00, 1'b0, 640, 80,
                32'h95600, 5'd8, 4'hF, 32'h95FE0, 5'd8, 4'hF};
    vecs[6] = '{4, 0, 2, 1, 1'b0, 32'h100, 12'h00F, 1'b0, 1, 1,
                32'h108, 5'd1, 4'hF, 32'h108, 5'd1, 4'hF};
    vecs[7] = '{5, 0, 2, 1, 1'b0, 32'h100, 12'h321, 1'b0, 2, 1,
                32'h108, 5'd2, 4'hC, 32'h108, 5'd2, 4'h3};
    vecs[8] = '{0, 0, 2, 1, 1'b1, 32'hFFFFFF00, 12'h777, 1'b0, 1, 1,
                32'h00095F00, 5'd1, 4'hF, 32'h00095F00, 5'd1, 4'hF};
    vecs[9] = '{1, 0, 40, 2, 1'b0, 32'h0, 12'h5A5, 1'b1, 42, 6,
                32'h0, 5'd8, 4'hC, 32'h540, 5'd5, 4'h3};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_write", {31'd0, m_write}, 32'd0);
    chk("rst_addr", m_addr, 32'd0);
    chk("rst_bc", {27'd0, m_bc}, 32'd0);
    chk("rst_be", {28'd0, m_be}, 32'd0);
    chk("rst_data", m_data, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_rdata", s_rdata, 32'd0);
    reset_n = 1'b1;
    clr_mon();
    rd(3'd1, d);
    chk("rst_ctrl", d, 32'd0);
    rd(3'd4, d);
    chk("rst_width", d, 32'd0);

    // Latency: start -> first write, last beat -> irq
    start_vec(vecs[0]);
    n = 0;
    for (int i = 0; i < 50 && !m_write; i++) begin
      @(negedge clk);
      n++;
    end
    chk("lat_start_to_write", n, 2);
    n = 0;
    for (int i = 0; i < 50 && !irq; i++) begin
      @(negedge clk);
      n++;
    end
    chk("lat_beat_to_irq", n, 2);
    finish_vec("lat_single", vecs[0]);

    // Table
    for (int i = 0; i < 10; i++) begin
      nm = $sformatf("vec%0d", i);
      start_vec(vecs[i]);
      rd(3'd1, d);
      chk({nm, "_busy"}, {31'd0, d[0]}, 32'd1);
      finish_vec(nm, vecs[i]);
    end

    // Start while busy ignored; register rewrites do not touch the running fill
    start_vec(vecs[1]);
    for (int i = 0; i < 200 && bursts < 1; i++) @(negedge clk);
    wr(3'd6, 32'hFFF);
    wr(3'd2, 32'd100);
    wr(3'd4, 32'd7);
    wr(3'd1, 32'h1);
    finish_vec("race", vecs[1]);

    // Reset mid-burst, then a clean restart
    start_vec(vecs[5]);
    for (int i = 0; i < 2000 && beats < 20; i++) @(negedge clk);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_write", {31'd0, m_write}, 32'd0);
    chk("abort_addr", m_addr, 32'd0);
    chk("abort_bc", {27'd0, m_bc}, 32'd0);
    chk("abort_be", {28'd0, m_be}, 32'd0);
    chk("abort_data", m_data, 32'd0);
    chk("abort_irq", {31'd0, irq}, 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    start_vec(vecs[1]);
    finish_vec("restart", vecs[1]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
